prbs5_checker: RTL and testbench
================================

# prbs5_checker

Serial PRBS checker sitting directly downstream of `top_lfsr_5`. It consumes the one-bit `MUX_out` stream, self-synchronises a local replica of the 5-bit maximal-length LFSR, and declares lock. Once locked, it counts bit errors and flags loss of lock. It lets the LFSR output be checked in hardware instead of only by file dump.

## Interface
Parameters:
- `WIDTH`, 5: LFSR length.
- `TAPS`, 5'b10100: feedback mask. The predicted bit is the XOR of `sr & TAPS`.
- `LOCK_GOOD`, 8: consecutive matches needed to declare lock (range 1..31).
- `LOSS_ERR`, 4: errors within one 31-bit window that force loss of lock (range 1..31).
- `ERR_W`, 16: width of the error counter.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `nrst`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: checker enable. Low forces IDLE.
- `bit_in`, input, 1: serial data, connected to `MUX_out`.
- `bit_valid`, input, 1: `bit_in` is sampled only when this is high.
- `locked`, output, 1: replica is in lock.
- `err_pulse`, output, 1: one-cycle pulse per mismatched bit while locked.
- `err_count`, output, ERR_W: saturating count of errors while locked.
- `loss_pulse`, output, 1: one-cycle pulse when lock is lost.
- `wrap_pulse`, output, 1: one-cycle pulse at each completed 31-bit period while locked.

## Operation
Internal state:
- `sr[WIDTH-1:0]`: replica register.
- Predicted bit `p = ^(sr & TAPS)`.
- Every shift is `sr <= {sr[WIDTH-2:0], x}`, where `x` is the bit shifted in.

State machine (every transition below requires `bit_valid`, except those from `enable` low):
- **IDLE**
  - Entered whenever `enable` is 0, from any state.
  - Holds `sr`, clears the fill and good counters.
  - Goes to FILL when `enable` is 1.
- **FILL**
  - Shifts in `bit_in` for WIDTH valid bits.
  - After the 5th bit: if `sr` (including the new bit) is all-zero, restart the fill count and stay in FILL. Otherwise go to ACQ.
- **ACQ**
  - Compares `bit_in` with `p`, then shifts in `bit_in` (self-synchronising).
  - A match increments `good_cnt`. A mismatch clears it to 0.
  - When `good_cnt` reaches LOCK_GOOD, go to LOCKED.
- **LOCKED**
  - Shifts in `p`, not `bit_in`, so the replica free-runs and each line error counts exactly once.
  - On a mismatch: pulse `err_pulse`, increment `err_count` (saturates at all-ones), increment `win_err`.
  - `win_cnt` counts valid bits 0..30. At the transition 30→0 it pulses `wrap_pulse` and clears `win_err`.
  - When `win_err` reaches LOSS_ERR: pulse `loss_pulse`, go to FILL, and clear `good_cnt`, `win_cnt` and `win_err`.

Rules for `err_count`:
- Cleared only by reset.
- Held in every state other than LOCKED.
- Not cleared on re-lock.

## Timing
Reset values: state = IDLE, `sr` = 0, all counters = 0, and every output = 0.

Output registration and latency:
- All outputs are registered.
- Pulses appear in the cycle after the clock edge that samples the causing valid bit, and last exactly one cycle.
- `locked` rises one cycle after the LOCK_GOOD-th consecutive match.
- `locked` falls in the same cycle as `loss_pulse`.

Minimum time to lock from a clean stream: WIDTH + LOCK_GOOD valid bits (13 at defaults).

Simultaneous and boundary events:
- `bit_valid` low: no state or counter change, and all pulses are 0.
- `enable` falling while LOCKED: `locked` drops the next cycle, with no `loss_pulse`.
- A wrap and the LOSS_ERR-th error on the same bit: `wrap_pulse`, `err_pulse` and `loss_pulse` all pulse, and the error counts toward loss before `win_err` is cleared.
- `err_count` at saturation: `err_pulse` still pulses.
- `nrst` asserted mid-operation: immediate asynchronous return to reset values.

Back-to-back valid bits are supported every cycle.

## Structure
- Package `prbs5_pkg` holds:
  - the state enum `chk_state_t` (IDLE, FILL, ACQ, LOCKED);
  - the localparam `PERIOD = 2**WIDTH - 1`;
  - the default TAPS constant.
- One sub-module, `prbs_replica`, holds `sr`, computes `p`, and has a load-select input choosing between `bit_in` and `p`.
- The FSM, the counters and the output registers live in `prbs5_checker`.

## Test plan
- **Clean lock.** Reset, `enable`=1, continuous clean LFSR stream with `bit_valid`=1.
  - Required: `locked` rises after 13 valid bits and `err_count` stays 0.
  - Required: `wrap_pulse` fires every 31 cycles thereafter.
- **Single error.** Flip one bit while locked.
  - Required: exactly one `err_pulse`, `err_count`=1, and `locked` remains 1.
- **Burst loss.** Flip 4 bits within one 31-bit window.
  - Required: `loss_pulse` on the 4th error, `locked`=0, `err_count`=4.
  - Required: with a clean stream afterwards, re-lock after 13 more valid bits.
- **All-zero input.** Drive `bit_in`=0 constantly.
  - Required: the checker stays in FILL and `locked` is never asserted.
- **Gaps.** Apply `bit_valid` at a 1-in-3 duty with a clean stream.
  - Required: lock after 13 valid bits and no errors.
  - Required: no pulses in any invalid cycle.
- **Disable and reset.**
  - Drop `enable` while LOCKED. Required: `locked`=0 next cycle, no `loss_pulse`, `err_count` held.
  - Assert `nrst` mid-stream. Required: all outputs return to 0 immediately.

Source files
------------

// File: rtl/prbs5_pkg.sv
// Shared types and constants for the PRBS5 checker slice.
package prbs5_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      ACQ,
      LOCKED
   } chk_state_t;

   localparam int PRBS_WIDTH = 5;
   localparam int PERIOD = 2**PRBS_WIDTH - 1;
   localparam logic [PRBS_WIDTH-1:0] DEFAULT_TAPS = 5'b10100;

endpackage

// File: rtl/prbs_replica.sv
// Local LFSR replica: shifts in either the received bit (acquisition)
// or its own prediction (free-running once locked).
module prbs_replica import prbs5_pkg::*; #(
   parameter int WIDTH = PRBS_WIDTH,
   parameter logic [WIDTH-1:0] TAPS = DEFAULT_TAPS
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             shift,
   input  logic             load_sel,
   input  logic             bit_in,
   output logic [WIDTH-1:0] sr,
   output logic             p
);

   assign p = ^(sr & TAPS);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         sr <= '0;
      end else if (shift) begin
         sr <= {sr[WIDTH-2:0], load_sel ? p : bit_in};
      end
   end

endmodule

// File: rtl/prbs5_checker.sv
// Self-synchronising PRBS5 checker: fills and acquires a replica LFSR,
// declares lock, then counts bit errors and detects loss of lock.
module prbs5_checker import prbs5_pkg::*; #(
   parameter int WIDTH = PRBS_WIDTH,
   parameter logic [WIDTH-1:0] TAPS = DEFAULT_TAPS,
   parameter int LOCK_GOOD = 8,
   parameter int LOSS_ERR = 4,
   parameter int ERR_W = 16
) (
   input  logic             clk,
   input  logic             nrst,
   input  logic             enable,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             locked,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic             loss_pulse,
   output logic             wrap_pulse
);

   localparam int WIN_LEN = 2**WIDTH - 1;
   localparam int CW = $clog2(WIN_LEN + 1);
   localparam int FW = $clog2(WIDTH + 1);

   chk_state_t state, state_next;
   logic [FW-1:0] fill_cnt;
   logic [CW-1:0] good_cnt, win_cnt, win_err;
   logic [WIDTH-1:0] sr;
   logic p, shift, load_sel, match, fill_last, fill_zero;
   logic lock_hit, err_hit, wrap_hit, loss_hit;

   assign match     = (bit_in == p);
   assign fill_last = (fill_cnt == FW'(WIDTH - 1));
   assign fill_zero = ({sr[WIDTH-2:0], bit_in} == '0);

   prbs_replica #(.WIDTH(WIDTH), .TAPS(TAPS)) u_replica (
      .clk      (clk),
      .nrst     (nrst),
      .shift    (shift),
      .load_sel (load_sel),
      .bit_in   (bit_in),
      .sr       (sr),
      .p        (p)
   );

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state <= IDLE;
      else       state <= state_next;
   end

   // A valid bit seen in IDLE is not discarded: it becomes the first fill bit.
   always_comb begin
      state_next = state;
      if (!enable) begin
         state_next = IDLE;
      end else if (bit_valid) begin
         unique case (state)
            IDLE:   state_next = FILL;
            FILL:   if (fill_last && !fill_zero) state_next = ACQ;
            ACQ:    if (lock_hit) state_next = LOCKED;
            LOCKED: if (loss_hit) state_next = FILL;
         endcase
      end
   end

   always_comb begin
      shift    = 1'b0;
      load_sel = 1'b0;
      lock_hit = 1'b0;
      err_hit  = 1'b0;
      wrap_hit = 1'b0;
      loss_hit = 1'b0;
      if (enable && bit_valid) begin
         unique case (state)
            IDLE, FILL: shift = 1'b1;
            ACQ: begin
               shift    = 1'b1;
               lock_hit = match && (good_cnt == CW'(LOCK_GOOD - 1));
            end
            LOCKED: begin
               shift    = 1'b1;
               load_sel = 1'b1;
               err_hit  = !match;
               wrap_hit = (win_cnt == CW'(WIN_LEN - 1));
               loss_hit = !match && (win_err == CW'(LOSS_ERR - 1));
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         fill_cnt   <= '0;
         good_cnt   <= '0;
         win_cnt    <= '0;
         win_err    <= '0;
         err_count  <= '0;
         locked     <= 1'b0;
         err_pulse  <= 1'b0;
         wrap_pulse <= 1'b0;
         loss_pulse <= 1'b0;
      end else begin
         err_pulse  <= err_hit;
         wrap_pulse <= wrap_hit;
         loss_pulse <= loss_hit;
         if (err_hit && !(&err_count)) err_count <= err_count + 1'b1;
         if (!enable) begin
            fill_cnt <= '0;
            good_cnt <= '0;
            win_cnt  <= '0;
            win_err  <= '0;
            locked   <= 1'b0;
         end else if (bit_valid) begin
            unique case (state)
               IDLE: fill_cnt <= FW'(1);
               FILL: begin
                  if (fill_last) begin
                     fill_cnt <= '0;
                     good_cnt <= '0;
                  end else begin
                     fill_cnt <= fill_cnt + 1'b1;
                  end
               end
               ACQ: begin
                  good_cnt <= match ? good_cnt + 1'b1 : '0;
                  if (lock_hit) begin
                     locked  <= 1'b1;
                     win_cnt <= '0;
                     win_err <= '0;
                  end
               end
               LOCKED: begin
                  if (loss_hit) begin
                     locked   <= 1'b0;
                     fill_cnt <= '0;
                     good_cnt <= '0;
                     win_cnt  <= '0;
                     win_err  <= '0;
                  end else begin
                     win_cnt <= wrap_hit ? '0 : win_cnt + 1'b1;
                     win_err <= wrap_hit ? '0 : win_err + CW'(err_hit);
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_prbs5_checker.sv
// Randomised bench for prbs5_checker against a bit-history reference model
// built from the recurrence s[n] = s[n-5] ^ s[n-3].
module tb_prbs5_checker;

   localparam int ERR_W = 4;
   localparam int ERR_MAX = (1 << ERR_W) - 1;
   localparam int LOCK_BITS = 13;

   logic clk = 1'b0;
   logic nrst, enable, bit_in, bit_valid;
   logic locked, err_pulse, loss_pulse, wrap_pulse;
   logic [ERR_W-1:0] err_count;

   always #5 clk = ~clk;

   prbs5_checker #(
      .WIDTH(5), .TAPS(5'b10100), .LOCK_GOOD(8), .LOSS_ERR(4), .ERR_W(ERR_W)
   ) dut (
      .clk        (clk),
      .nrst       (nrst),
      .enable     (enable),
      .bit_in     (bit_in),
      .bit_valid  (bit_valid),
      .locked     (locked),
      .err_pulse  (err_pulse),
      .err_count  (err_count),
      .loss_pulse (loss_pulse),
      .wrap_pulse (wrap_pulse)
   );

   int n_compared = 0;
   int n_mismatched = 0;
   int gap_pulses = 0;

   // Reference model: mode 0 idle, 1 fill, 2 acquire, 3 locked.
   int m_mode, m_fill, m_good, m_win, m_werr, m_errs;
   bit m_locked, m_err, m_wrap, m_loss;
   bit m_hist[$];
   bit g_hist[$];

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic bit prbsNext(input bit h[$]);
      return h[0] ^ h[2];
   endfunction

   function automatic bit genBit();
      bit b;
      b = prbsNext(g_hist);
      g_hist.push_back(b);
      void'(g_hist.pop_front());
      return b;
   endfunction

   function automatic void modelShift(input bit x);
      m_hist.push_back(x);
      void'(m_hist.pop_front());
   endfunction

   function automatic void modelReset();
      m_mode = 0; m_fill = 0; m_good = 0; m_win = 0; m_werr = 0; m_errs = 0;
      m_locked = 0; m_err = 0; m_wrap = 0; m_loss = 0;
      m_hist.delete();
      repeat (5) m_hist.push_back(1'b0);
   endfunction

   function automatic void modelStep(input bit en, input bit v, input bit b);
      bit p, all_zero, wrapped;
      m_err = 0; m_wrap = 0; m_loss = 0;
      if (!en) begin
         m_mode = 0; m_fill = 0; m_good = 0; m_win = 0; m_werr = 0; m_locked = 0;
         return;
      end
      if (!v) return;
      p = prbsNext(m_hist);
      case (m_mode)
         0: begin modelShift(b); m_fill = 1; m_mode = 1; end
         1: begin
            modelShift(b);
            m_fill++;
            if (m_fill == 5) begin
               m_fill = 0;
               all_zero = 1;
               foreach (m_hist[i]) if (m_hist[i]) all_zero = 0;
               if (!all_zero) begin m_mode = 2; m_good = 0; end
            end
         end
         2: begin
            modelShift(b);
            m_good = (b == p) ? m_good + 1 : 0;
            if (m_good == 8) begin m_mode = 3; m_locked = 1; m_win = 0; m_werr = 0; end
         end
         default: begin
            modelShift(p);
            wrapped = 0;
            if (b != p) begin
               m_err = 1;
               if (m_errs < ERR_MAX) m_errs++;
               m_werr++;
            end
            m_win++;
            if (m_win == 31) begin m_wrap = 1; m_win = 0; wrapped = 1; end
            if (m_werr == 4) begin
               m_loss = 1; m_mode = 1; m_locked = 0;
               m_fill = 0; m_good = 0; m_win = 0; m_werr = 0;
            end else if (wrapped) begin
               m_werr = 0;
            end
         end
      endcase
   endfunction

   task automatic applyStimulus(input bit en, input bit v, input bit b);
      enable = en; bit_valid = v; bit_in = b;
      @(posedge clk);
      modelStep(en, v, b);
      #1;
      checkOutput("locked", locked, m_locked);
      checkOutput("err_pulse", err_pulse, m_err);
      checkOutput("wrap_pulse", wrap_pulse, m_wrap);
      checkOutput("loss_pulse", loss_pulse, m_loss);
      checkOutput("err_count", err_count, m_errs);
      if (!v && (err_pulse || wrap_pulse || loss_pulse)) gap_pulses++;
   endtask

   task automatic sendBit(input bit en, input bit v, input bit flip);
      bit b;
      if (v) b = genBit() ^ flip;
      else   b = 1'($urandom);
      applyStimulus(en, v, b);
   endtask

   task automatic countRelock(input string tag);
      int lock_at = 0;
      for (int i = 1; i <= 20; i++) begin
         sendBit(1, 1, 0);
         if (locked && lock_at == 0) lock_at = i;
      end
      checkOutput(tag, lock_at, LOCK_BITS);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int seed, wraps, errs_seen, waited, losses, seen, nvalid, lock_at, sat_cycles;
      bit v;
      nrst = 1'b0; enable = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
      modelReset();
      seed = $urandom_range(1, 31);
      for (int i = 0; i < 5; i++) g_hist.push_back(seed[i]);
      repeat (2) @(negedge clk);
      checkOutput("rst_locked", locked, 0);
      checkOutput("rst_err_pulse", err_pulse, 0);
      checkOutput("rst_err_count", err_count, 0);
      checkOutput("rst_loss_pulse", loss_pulse, 0);
      checkOutput("rst_wrap_pulse", wrap_pulse, 0);
      nrst = 1'b1;

      countRelock("lock_latency");
      checkOutput("clean_err_count", err_count, 0);
      wraps = 0;
      repeat (93) begin sendBit(1, 1, 0); if (wrap_pulse) wraps++; end
      checkOutput("wrap_count", wraps, 3);

      sendBit(1, 1, 1);
      errs_seen = int'(err_pulse);
      repeat (5) begin sendBit(1, 1, 0); errs_seen += int'(err_pulse); end
      checkOutput("single_err_pulses", errs_seen, 1);
      checkOutput("single_err_count", err_count, 1);
      checkOutput("single_locked", locked, 1);

      waited = 0;
      do begin sendBit(1, 1, 0); waited++; end while (!wrap_pulse && waited < 40);
      checkOutput("wrap_seen", wrap_pulse, 1);
      losses = 0;
      for (int i = 0; i < 4; i++) begin
         sendBit(1, 1, 1);
         losses += int'(loss_pulse);
         if (i < 3) begin sendBit(1, 1, 0); losses += int'(loss_pulse); end
      end
      checkOutput("burst_loss", losses, 1);
      checkOutput("burst_unlocked", locked, 0);
      checkOutput("burst_err_count", err_count, 5);
      countRelock("relock_latency");

      repeat (1500) sendBit($urandom_range(0, 299) != 0, $urandom_range(0, 2) != 0,
                            $urandom_range(0, 39) == 0);

      sat_cycles = 0;
      while (err_count != ERR_MAX && sat_cycles < 3000) begin
         sendBit(1, 1, (sat_cycles % 10) == 9);
         sat_cycles++;
      end
      checkOutput("err_saturated", err_count, ERR_MAX);
      waited = 0;
      while (!locked && waited < 40) begin sendBit(1, 1, 0); waited++; end
      checkOutput("sat_relocked", locked, 1);
      sendBit(1, 1, 1);
      checkOutput("sat_err_pulse", err_pulse, 1);
      checkOutput("sat_err_count", err_count, ERR_MAX);

      applyStimulus(0, 1, 0);
      seen = 0;
      repeat (200) begin applyStimulus(1, 1, 0); if (locked) seen = 1; end
      checkOutput("zero_never_locked", seen, 0);

      applyStimulus(0, 0, 0);
      gap_pulses = 0; nvalid = 0; lock_at = 0;
      for (int i = 0; i < 240; i++) begin
         v = (i % 3 == 0);
         sendBit(1, v, 0);
         if (v) nvalid++;
         if (locked && lock_at == 0) lock_at = nvalid;
      end
      checkOutput("gap_lock_latency", lock_at, LOCK_BITS);
      checkOutput("gap_pulses", gap_pulses, 0);
      checkOutput("gap_err_count", err_count, ERR_MAX);

      checkOutput("pre_disable_locked", locked, 1);
      sendBit(0, 1, 0);
      checkOutput("disable_locked", locked, 0);
      checkOutput("disable_no_loss", loss_pulse, 0);
      checkOutput("disable_err_held", err_count, ERR_MAX);

      countRelock("enable_relock");
      #2;
      nrst = 1'b0;
      #1;
      checkOutput("async_rst_locked", locked, 0);
      checkOutput("async_rst_err_count", err_count, 0);
      checkOutput("async_rst_err_pulse", err_pulse, 0);
      checkOutput("async_rst_loss_pulse", loss_pulse, 0);
      checkOutput("async_rst_wrap_pulse", wrap_pulse, 0);
      modelReset();
      @(negedge clk);
      nrst = 1'b1;
      countRelock("post_rst_lock");
      checkOutput("post_rst_err_count", err_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
